// File: rtl/pcu_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pcu_fetch_ctrl_pkg
// Shared definitions for the 2-stage 4-bit CPU: datapath widths, the fetch
// controller state encoding, opcode constants decoded by the execute stage,
// and a small PC increment helper.
// No ports (package).
// ---------------------------------------------------------------------------
package pcu_fetch_ctrl_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    HALT   = 2'd3
  } state_t;

  // Upper nibble of the instruction word; the lower nibble is the immediate.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Program addresses wrap silently at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/pcu_fetch_ctrl_pc.sv
// ---------------------------------------------------------------------------
// pcu_fetch_ctrl_pc
// Loadable program counter register used as the fetch address holder.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset (clears q to 0)
//   load   in   capture d on the next rising edge
//   d      in   next program counter value
//   q      out  current program counter
// ---------------------------------------------------------------------------
module pcu_fetch_ctrl_pc
  import pcu_fetch_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pcu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pcu_fetch_ctrl
// Fetch-side controller: owns the PC, addresses the instruction ROM, fills the
// IF/EX latch, and performs redirects, flushes, stalls and halt.
// Optional feature: define PCU_RET_STACK_EN to add a one-entry link register
// for call/return; otherwise call_req acts as jump_req and ret_req is ignored.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   stall      in   execute stage cannot accept a new instruction
//   halt_req   in   execute stage decoded HALT
//   jump_req   in   taken jump/branch
//   jump_addr  in   redirect target (jump and call)
//   call_req   in   call redirect
//   ret_req    in   return redirect
//   imem_addr  out  ROM address (= pc)
//   imem_data  in   ROM read data for imem_addr, same cycle
//   if_valid   out  if_instr holds a real instruction
//   if_instr   out  latched instruction
//   if_pc      out  address of if_instr
//   pc         out  current fetch address
//   halted     out  core is in HALT
// ---------------------------------------------------------------------------
module pcu_fetch_ctrl
  import pcu_fetch_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               jump_req,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               call_req,
  input  logic               ret_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  state_t              state, state_nxt;
  logic                pc_load;
  logic [ADDR_W-1:0]   pc_d;
  logic                fetch_en;
  logic                if_valid_nxt;
  logic                redirect_req;
  logic [ADDR_W-1:0]   redirect_pc;

`ifdef PCU_RET_STACK_EN
  logic [ADDR_W-1:0]   link;
  logic                link_load;
`else
  logic                unused_ret;
  assign unused_ret = ret_req;
`endif

  pcu_fetch_ctrl_pc u_pc (
    .clock (clock),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc)
  );

  assign imem_addr = pc;
  assign halted    = (state == HALT);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // IF/EX latch: instruction and its address only move on a real fetch, so
  // they stay put across stalls, bubbles and halt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      if_valid <= if_valid_nxt;
      if (fetch_en) begin
        if_instr <= imem_data;
        if_pc    <= pc;
      end
    end
  end

`ifdef PCU_RET_STACK_EN
  // The call sits in the IF/EX latch when it fires, so its return address is
  // simply the instruction after it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      link <= '0;
    end else if (link_load) begin
      link <= pc_inc(if_pc);
    end
  end
`endif

  // Next-state, next-pc mux and latch control. Redirect sources resolve first
  // (ret over call/jump); halt outranks any redirect, and a redirect outranks
  // stall so a stalled branch still flushes.
  always_comb begin
    redirect_req = jump_req | call_req;
    redirect_pc  = jump_addr;
`ifdef PCU_RET_STACK_EN
    link_load    = 1'b0;
    if (ret_req) begin
      redirect_req = 1'b1;
      redirect_pc  = link;
    end
`endif
    state_nxt    = state;
    pc_load      = 1'b0;
    pc_d         = pc_inc(pc);
    fetch_en     = 1'b0;
    if_valid_nxt = if_valid;

    case (state)
      FILL, BUBBLE: begin
        if (!stall) begin
          fetch_en     = 1'b1;
          pc_load      = 1'b1;
          if_valid_nxt = 1'b1;
          state_nxt    = RUN;
        end
      end
      RUN: begin
        if (halt_req) begin
          if_valid_nxt = 1'b0;
          state_nxt    = HALT;
        end else if (redirect_req) begin
          pc_load      = 1'b1;
          pc_d         = redirect_pc;
          if_valid_nxt = 1'b0;
          state_nxt    = BUBBLE;
`ifdef PCU_RET_STACK_EN
          link_load    = call_req & ~ret_req;
`endif
        end else if (!stall) begin
          fetch_en     = 1'b1;
          pc_load      = 1'b1;
          if_valid_nxt = 1'b1;
        end
      end
      HALT: begin
        if_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_pcu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pcu_fetch_ctrl
// Directed bench for pcu_fetch_ctrl. The ROM model returns 0x10 + address.
// Works with or without PCU_RET_STACK_EN; the call/return expectations follow
// whichever build is compiled.
// ---------------------------------------------------------------------------
module tb_pcu_fetch_ctrl;
  import pcu_fetch_ctrl_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               stall, halt_req, jump_req, call_req, ret_req;
  logic [ADDR_W-1:0]  jump_addr;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic [ADDR_W-1:0]  pc;
  logic               halted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              stall;
    logic              halt;
    logic              jump;
    logic [ADDR_W-1:0] jaddr;
    logic              call;
    logic              ret;
    logic              chk_latch;
    logic              exp_valid;
    logic [7:0]        exp_instr;
    logic [ADDR_W-1:0] exp_ifpc;
    logic [ADDR_W-1:0] exp_pc;
    logic              exp_halted;
  } vec_t;

  vec_t vecs[$];

  pcu_fetch_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .halt_req  (halt_req),
    .jump_req  (jump_req),
    .jump_addr (jump_addr),
    .call_req  (call_req),
    .ret_req   (ret_req),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .pc        (pc),
    .halted    (halted)
  );

  always #5 clock = ~clock;

  assign imem_data = 8'h10 + {4'h0, imem_addr};

  function automatic vec_t mk(input logic s, input logic h, input logic j,
                              input logic [3:0] ja, input logic c, input logic r,
                              input logic chk, input logic v, input logic [7:0] ins,
                              input logic [3:0] ipc, input logic [3:0] p,
                              input logic hl);
    vec_t t;
    t.stall = s; t.halt = h; t.jump = j; t.jaddr = ja; t.call = c; t.ret = r;
    t.chk_latch = chk; t.exp_valid = v; t.exp_instr = ins;
    t.exp_ifpc = ipc; t.exp_pc = p; t.exp_halted = hl;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [7:0] act,
                              input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs now (away from the edge), then sample 1 time unit after the
  // next rising edge.
  task automatic apply_stimulus(input vec_t v);
    stall     = v.stall;
    halt_req  = v.halt;
    jump_req  = v.jump;
    jump_addr = v.jaddr;
    call_req  = v.call;
    ret_req   = v.ret;
    @(posedge clock);
    #1;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    apply_stimulus(v);
    check_output({tag, " if_valid"}, {7'd0, if_valid}, {7'd0, v.exp_valid});
    check_output({tag, " pc"}, {4'd0, pc}, {4'd0, v.exp_pc});
    check_output({tag, " halted"}, {7'd0, halted}, {7'd0, v.exp_halted});
    if (v.chk_latch) begin
      check_output({tag, " if_instr"}, if_instr, v.exp_instr);
      check_output({tag, " if_pc"}, {4'd0, if_pc}, {4'd0, v.exp_ifpc});
    end
  endtask

  initial begin
    // Table: stall halt jump jaddr call ret | chk valid instr ifpc pc halted
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h10,4'h0,4'h1,0)); // FILL fetch
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h11,4'h1,4'h2,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h12,4'h2,4'h3,0));
    vecs.push_back(mk(1,0,0,4'h0,0,0, 1,1,8'h12,4'h2,4'h3,0)); // stall x3
    vecs.push_back(mk(1,0,0,4'h0,0,0, 1,1,8'h12,4'h2,4'h3,0));
    vecs.push_back(mk(1,0,0,4'h0,0,0, 1,1,8'h12,4'h2,4'h3,0));
    vecs.push_back(mk(1,0,1,4'hC,0,0, 0,0,8'h00,4'h0,4'hC,0)); // stall+jump
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h1C,4'hC,4'hD,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h1D,4'hD,4'hE,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h1E,4'hE,4'hF,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h1F,4'hF,4'h0,0)); // wrap
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h10,4'h0,4'h1,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h11,4'h1,4'h2,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h12,4'h2,4'h3,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h13,4'h3,4'h4,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h14,4'h4,4'h5,0));
    vecs.push_back(mk(0,0,1,4'h9,0,0, 0,0,8'h00,4'h0,4'h9,0)); // jump 5->9
    vecs.push_back(mk(0,0,1,4'h3,0,0, 1,1,8'h19,4'h9,4'hA,0)); // ignored in BUBBLE
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h1A,4'hA,4'hB,0));
    vecs.push_back(mk(0,0,1,4'h6,0,0, 0,0,8'h00,4'h0,4'h6,0)); // jump to 6
    vecs.push_back(mk(1,0,0,4'h0,0,0, 0,0,8'h00,4'h0,4'h6,0)); // stall in BUBBLE
    vecs.push_back(mk(0,0,0,4'h0,0,0, 1,1,8'h16,4'h6,4'h7,0));
    vecs.push_back(mk(0,1,1,4'h0,0,0, 0,0,8'h00,4'h0,4'h7,1)); // halt beats jump

    stall = 0; halt_req = 0; jump_req = 0; call_req = 0; ret_req = 0;
    jump_addr = '0;
    reset = 1'b0;
    #12;
    check_output("reset pc", {4'd0, pc}, 8'h00);
    check_output("reset if_valid", {7'd0, if_valid}, 8'h00);
    check_output("reset if_instr", if_instr, 8'h00);
    check_output("reset if_pc", {4'd0, if_pc}, 8'h00);
    check_output("reset halted", {7'd0, halted}, 8'h00);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_row(vecs[i], $sformatf("row%0d", i));
    end

    // Halt must hold for many cycles regardless of other requests.
    for (int i = 0; i < 10; i++) begin
      run_row(mk(i[0],1,1,4'h2,1,1, 0,0,8'h00,4'h0,4'h7,1), $sformatf("halt%0d", i));
      check_output($sformatf("halt%0d if_pc", i), {4'd0, if_pc}, 8'h06);
    end

    // Asynchronous reset pulse mid-halt.
    #2 reset = 1'b0;
    #1;
    check_output("midreset pc", {4'd0, pc}, 8'h00);
    check_output("midreset halted", {7'd0, halted}, 8'h00);
    check_output("midreset if_valid", {7'd0, if_valid}, 8'h00);
    #1 reset = 1'b1;
    run_row(mk(1,0,0,4'h0,0,0, 0,0,8'h00,4'h0,4'h0,0), "fill_stall");
    run_row(mk(0,0,0,4'h0,0,0, 1,1,8'h10,4'h0,4'h1,0), "fill_go");

    // Call / return sequence starting from if_pc=4, pc=5.
    for (int i = 0; i < 4; i++) begin
      run_row(mk(0,0,0,4'h0,0,0, 1,1,8'h11 + 8'(i),4'(i + 1),4'(i + 2),0),
              $sformatf("pre_call%0d", i));
    end
    run_row(mk(0,0,0,4'hC,1,0, 0,0,8'h00,4'h0,4'hC,0), "call");
    run_row(mk(0,0,0,4'h0,0,0, 1,1,8'h1C,4'hC,4'hD,0), "call_tgt");
    run_row(mk(0,0,0,4'h0,0,0, 1,1,8'h1D,4'hD,4'hE,0), "call_next");
`ifdef PCU_RET_STACK_EN
    run_row(mk(0,0,0,4'h3,0,1, 0,0,8'h00,4'h0,4'h5,0), "ret");
    run_row(mk(0,0,0,4'h0,0,0, 1,1,8'h15,4'h5,4'h6,0), "ret_tgt");
    run_row(mk(0,0,0,4'h2,1,1, 0,0,8'h00,4'h0,4'h5,0), "call_ret");
    run_row(mk(0,0,0,4'h0,0,0, 1,1,8'h15,4'h5,4'h6,0), "call_ret_tgt");
`else
    run_row(mk(0,0,0,4'h3,0,1, 1,1,8'h1E,4'hE,4'hF,0), "ret_ignored");
    run_row(mk(0,0,0,4'h0,0,0, 1,1,8'h1F,4'hF,4'h0,0), "ret_next");
    run_row(mk(0,0,0,4'h2,1,1, 0,0,8'h00,4'h0,4'h2,0), "call_as_jump");
    run_row(mk(0,0,0,4'h0,0,0, 1,1,8'h12,4'h2,4'h3,0), "call_as_jump_tgt");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
